// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-register-read handshake bundle.
//
// Upstream (fetch) side : in_valid, in_ready, in_instr, in_pc
// Downstream side       : out_valid, out_ready and the decoded fields
//                         (opcode, rd, rs1, rs2, funct3, funct7, imm, pc,
//                         rd_we, illegal, illegal_cnt)
//
// slave  : the decode stage itself
// master : whatever drives fetch data and consumes the decoded result
interface decode_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  pc;
  logic             rd_we;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, opcode, rd, rs1, rs2, funct3, funct7,
           imm, pc, rd_we, illegal, illegal_cnt
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, opcode, rd, rs1, rs2, funct3, funct7,
           imm, pc, rd_we, illegal, illegal_cnt
  );

endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage sitting between fetch and register-file read.
// Splits each instruction into its fields, builds the XLEN-wide sign-extended
// immediate, flags illegal encodings and keeps a saturating illegal-instruction count.
// Holds one instruction under a valid/ready handshake at one instruction per cycle.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : drop the held instruction and any same-cycle accept (branch redirect)
//   bus    : decode_stage_if.slave
//            in_valid/in_ready/in_instr/in_pc  fetch side
//            out_valid/out_ready               downstream handshake
//            opcode, rd, rs1, rs2, funct3, funct7, imm, pc, rd_we, illegal,
//            illegal_cnt                       registered decode results
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            rd_we;
    logic            illegal;
  } dec_t;

  dec_t             dec_d, dec_q;
  logic             valid_q;
  logic             rdy_en_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // Decode (combinational, from the incoming word)
  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
  logic        ill;
  logic [31:0] imm32;

  assign instr = bus.in_instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  // Format classification and illegal-encoding checks. Every listed opcode
  // ends in 2'b11, so a non-32-bit encoding always lands in the default arm.
  always_comb begin
    fmt_r = 1'b0;
    fmt_i = 1'b0;
    fmt_s = 1'b0;
    fmt_b = 1'b0;
    fmt_u = 1'b0;
    fmt_j = 1'b0;
    ill   = 1'b0;
    case (opc)
      OpR: begin
        fmt_r = 1'b1;
        if (f7 == 7'b0100000) begin
          ill = !((f3 == 3'b000) || (f3 == 3'b101));
        end else begin
          ill = (f7 != 7'b0000000);
        end
      end
      OpImm: begin
        fmt_i = 1'b1;
        // RV64 shifts use a 6-bit shamt, so only instr[31:26] carries funct bits.
        if (f3 == 3'b001) begin
          ill = (XLEN == 32) ? (instr[31:25] != 7'b0000000) : (instr[31:26] != 6'b000000);
        end else if (f3 == 3'b101) begin
          if (XLEN == 32) begin
            ill = !((instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000));
          end else begin
            ill = !((instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000));
          end
        end
      end
      OpLoad: begin
        fmt_i = 1'b1;
        ill   = (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
      end
      OpJalr: begin
        fmt_i = 1'b1;
        ill   = (f3 != 3'b000);
      end
      OpStore: begin
        fmt_s = 1'b1;
        ill   = f3[2] || ((XLEN == 32) && (f3 == 3'b011));
      end
      OpBranch: begin
        fmt_b = 1'b1;
        ill   = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OpLui, OpAuipc: fmt_u = 1'b1;
      OpJal:          fmt_j = 1'b1;
      default:        ill   = 1'b1;
    endcase
  end

  // Immediate assembly; unknown formats and R-type produce 0.
  always_comb begin
    imm32 = 32'h0;
    if (fmt_i) begin
      imm32 = {{20{instr[31]}}, instr[31:20]};
    end else if (fmt_s) begin
      imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    end else if (fmt_b) begin
      imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    end else if (fmt_u) begin
      imm32 = {instr[31:12], 12'h000};
    end else if (fmt_j) begin
      imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end
  end

  // Fields a format does not use are forced to 0 so nothing stale leaks through.
  always_comb begin
    dec_d         = '0;
    dec_d.opcode  = opc;
    dec_d.rd      = (fmt_r || fmt_i || fmt_u || fmt_j) ? instr[11:7]  : 5'd0;
    dec_d.rs1     = (fmt_r || fmt_i || fmt_s || fmt_b) ? instr[19:15] : 5'd0;
    dec_d.rs2     = (fmt_r || fmt_s || fmt_b)          ? instr[24:20] : 5'd0;
    dec_d.funct3  = (fmt_r || fmt_i || fmt_s || fmt_b) ? f3           : 3'd0;
    dec_d.funct7  = fmt_r ? f7 : 7'd0;
    dec_d.imm     = XLEN'($signed(imm32));
    dec_d.pc      = bus.in_pc;
    dec_d.rd_we   = (fmt_r || fmt_i || fmt_u || fmt_j) && (instr[11:7] != 5'd0) && !ill;
    dec_d.illegal = ill;
  end

  // Handshake. rdy_en_q keeps in_ready low while in reset and for the first
  // edge after release, so every output reads 0 during reset.
  assign bus.in_ready = rdy_en_q && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      valid_q  <= 1'b0;
      dec_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (flush) begin
        valid_q <= 1'b0;
        dec_q   <= '0;
      end else if (accept) begin
        valid_q <= 1'b1;
        dec_q   <= dec_d;
      end else if (!valid_q || bus.out_ready) begin
        // Slot drained with nothing new: return to the all-zero idle state.
        valid_q <= 1'b0;
        dec_q   <= '0;
      end
      if (accept && !flush && dec_d.illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.opcode      = dec_q.opcode;
  assign bus.rd          = dec_q.rd;
  assign bus.rs1         = dec_q.rs1;
  assign bus.rs2         = dec_q.rs2;
  assign bus.funct3      = dec_q.funct3;
  assign bus.funct7      = dec_q.funct7;
  assign bus.imm         = dec_q.imm;
  assign bus.pc          = dec_q.pc;
  assign bus.rd_we       = dec_q.rd_we;
  assign bus.illegal     = dec_q.illegal;
  assign bus.illegal_cnt = cnt_q;

endmodule
